// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA window compositor:
//     - COORD_W     : width of the VGA pixel coordinates (xpos / ypos)
//     - mode_e      : display modes selectable on mode_sel / shown on mode_active
//     - LUMA_*      : integer luma weights and the final shift, so that
//                     gray = (2*R + 5*G + 1*B) >> 3
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        MODE_RGB       = 2'd0,
        MODE_GRAY_BUF  = 2'd1,
        MODE_GRAY_CALC = 2'd2,
        MODE_THRESH    = 2'd3
    } mode_e;

    // The weights sum to 8, so the shift by 3 normalises the result back into
    // CH_W bits and no saturation is ever required.
    localparam int LUMA_WR    = 2;
    localparam int LUMA_WG    = 5;
    localparam int LUMA_WB    = 1;
    localparam int LUMA_SHIFT = 3;

    // Extra sum bits needed above CH_W: ceil(log2(2+5+1)) = 3.
    localparam int LUMA_GUARD = 3;

endpackage : vga_pkg

// File: rtl/vga_window_compositor_gray_luma.sv
// ---------------------------------------------------------------------------
// gray_luma
//   Purely combinational RGB -> gray conversion using the integer weights
//   from vga_pkg: gray = (2*R + 5*G + B) >> 3.
//
// Ports
//   rgb   in   3*CH_W  {R,G,B}, R in the MSBs
//   gray  out  CH_W    luma value, always fits without saturation
// ---------------------------------------------------------------------------
module gray_luma
    import vga_pkg::*;
#(
    parameter int CH_W = 4
) (
    input  logic [3*CH_W-1:0] rgb,
    output logic [CH_W-1:0]   gray
);

    localparam int SUM_W = CH_W + LUMA_GUARD;

    logic [SUM_W-1:0] r_ext;
    logic [SUM_W-1:0] g_ext;
    logic [SUM_W-1:0] b_ext;
    logic [SUM_W-1:0] sum;

    assign r_ext = SUM_W'(rgb[3*CH_W-1 -: CH_W]);
    assign g_ext = SUM_W'(rgb[2*CH_W-1 -: CH_W]);
    assign b_ext = SUM_W'(rgb[CH_W-1   -: CH_W]);

    // Constant-weight products reduce to shift-and-add logic.
    assign sum = SUM_W'(LUMA_WR) * r_ext
               + SUM_W'(LUMA_WG) * g_ext
               + SUM_W'(LUMA_WB) * b_ext;

    assign gray = CH_W'(sum >> LUMA_SHIFT);

endmodule : gray_luma

// File: rtl/vga_window_compositor.sv
// ---------------------------------------------------------------------------
// vga_window_compositor
//   Sits between the frame buffer and the VGA timing generator. While the
//   VGA scan is inside a WIN_W x WIN_H window at (X_OFF, Y_OFF) it issues
//   linear read addresses to the RGB and gray buffer ports, realigns the
//   returned data with the pixel stream and renders one of four display
//   modes. Everything outside the window or the active area is black.
//   The applied mode is latched only at the window origin (frame start).
//
//   All state advances on clk_50 cycles qualified by ptick.
//   Latency from (xpos, ypos) to pixel_rgb: RD_LAT+1 pixel ticks.
//
// Ports
//   clk_50        in   1          system clock
//   rst_n         in   1          asynchronous active-low reset
//   ptick         in   1          pixel tick enable
//   active        in   1          VGA active-area flag for (xpos, ypos)
//   xpos, ypos    in   COORD_W    current pixel coordinates
//   mode_sel      in   2          requested mode (mode_e encoding)
//   thresh        in   CH_W       threshold used in MODE_THRESH
//   rd_addr_rgb   out  ADDR_W     read address to the RGB buffer port
//   rd_data_rgb   in   3*CH_W     RGB word, RD_LAT ticks after the address
//   rd_addr_gray  out  ADDR_W     read address to the gray port (= rgb addr)
//   rd_data_gray  in   CH_W       gray word, RD_LAT ticks after the address
//   pixel_rgb     out  3*OUT_BPC  {R,G,B} towards the VGA DAC
//   mode_active   out  2          mode currently applied
//   frame_start   out  1          one-clk pulse when the origin is issued
// ---------------------------------------------------------------------------
module vga_window_compositor
    import vga_pkg::*;
#(
    parameter int WIN_W   = 120,
    parameter int WIN_H   = 120,
    parameter int X_OFF   = 0,
    parameter int Y_OFF   = 0,
    parameter int ADDR_W  = 14,
    parameter int CH_W    = 4,
    parameter int OUT_BPC = 1,
    parameter int RD_LAT  = 1
) (
    input  logic                   clk_50,
    input  logic                   rst_n,
    input  logic                   ptick,
    input  logic                   active,
    input  logic [COORD_W-1:0]     xpos,
    input  logic [COORD_W-1:0]     ypos,
    input  logic [1:0]             mode_sel,
    input  logic [CH_W-1:0]        thresh,
    output logic [ADDR_W-1:0]      rd_addr_rgb,
    input  logic [3*CH_W-1:0]      rd_data_rgb,
    output logic [ADDR_W-1:0]      rd_addr_gray,
    input  logic [CH_W-1:0]        rd_data_gray,
    output logic [3*OUT_BPC-1:0]   pixel_rgb,
    output logic [1:0]             mode_active,
    output logic                   frame_start
);

    localparam int OUT_W = 3 * OUT_BPC;

    // Window bounds, one bit wider than the coordinates so that the
    // subtraction below can wrap without aliasing into the window.
    localparam logic [COORD_W:0]   X_LO   = (COORD_W+1)'(X_OFF);
    localparam logic [COORD_W:0]   Y_LO   = (COORD_W+1)'(Y_OFF);
    localparam logic [COORD_W:0]   W_SPAN = (COORD_W+1)'(WIN_W);
    localparam logic [COORD_W:0]   H_SPAN = (COORD_W+1)'(WIN_H);
    localparam logic [COORD_W-1:0] X_ORG  = COORD_W'(X_OFF);
    localparam logic [COORD_W-1:0] Y_ORG  = COORD_W'(Y_OFF);

    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(WIN_W * WIN_H - 1);

    // ------------------------------------------------------------------
    // Window decode
    // ------------------------------------------------------------------
    logic [COORD_W:0] x_rel;
    logic [COORD_W:0] y_rel;
    logic             in_win;
    logic             origin;

    // A coordinate left of / above the window wraps to a value >= 2**COORD_W,
    // which is never smaller than the span, so one unsigned compare per axis
    // covers both edges.
    assign x_rel  = {1'b0, xpos} - X_LO;
    assign y_rel  = {1'b0, ypos} - Y_LO;
    assign in_win = active && (x_rel < W_SPAN) && (y_rel < H_SPAN);
    assign origin = active && (xpos == X_ORG) && (ypos == Y_ORG);

    // ------------------------------------------------------------------
    // Address counter, mode register, frame_start
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_q;
    mode_e             mode_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            mode_q      <= MODE_RGB;
            frame_start <= 1'b0;
        end else begin
            // A pulse, not state: cleared on every clk that is not the
            // origin tick so it lasts exactly one clk_50 cycle.
            frame_start <= ptick && origin;
            if (ptick) begin
                if (origin) begin
                    addr_q <= '0;
                    mode_q <= mode_e'(mode_sel);
                end else if (in_win && (addr_q != ADDR_LAST)) begin
                    // Raster order inside the window makes a running
                    // counter equal to (y-Y_OFF)*WIN_W + (x-X_OFF).
                    // The stop at ADDR_LAST keeps a partial frame after a
                    // mid-frame reset from wrapping into address 0.
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    assign rd_addr_rgb  = addr_q;
    assign rd_addr_gray = addr_q;
    assign mode_active  = mode_q;

    // ------------------------------------------------------------------
    // Valid pipe: stage 0 lines up with the registered address, stage
    // RD_LAT lines up with the data returned by the buffer.
    // ------------------------------------------------------------------
    logic [RD_LAT:0] valid_q;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (ptick) begin
            valid_q <= {valid_q[RD_LAT-1:0], in_win};
        end
    end

    // ------------------------------------------------------------------
    // Mode rendering
    // ------------------------------------------------------------------
    logic [CH_W-1:0]  luma;
    logic [CH_W-1:0]  r_ch;
    logic [CH_W-1:0]  g_ch;
    logic [CH_W-1:0]  b_ch;
    logic [OUT_W-1:0] pix_next;

    gray_luma #(
        .CH_W (CH_W)
    ) u_gray_luma (
        .rgb  (rd_data_rgb),
        .gray (luma)
    );

    // Keep the OUT_BPC most significant bits of a channel.
    function automatic logic [OUT_BPC-1:0] out_bits(input logic [CH_W-1:0] ch);
        return OUT_BPC'(ch >> (CH_W - OUT_BPC));
    endfunction

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        r_ch = '0;
        g_ch = '0;
        b_ch = '0;
        case (mode_q)
            MODE_RGB: begin
                r_ch = rd_data_rgb[3*CH_W-1 -: CH_W];
                g_ch = rd_data_rgb[2*CH_W-1 -: CH_W];
                b_ch = rd_data_rgb[CH_W-1   -: CH_W];
            end
            MODE_GRAY_BUF: begin
                r_ch = rd_data_gray;
                g_ch = rd_data_gray;
                b_ch = rd_data_gray;
            end
            MODE_GRAY_CALC: begin
                r_ch = luma;
                g_ch = luma;
                b_ch = luma;
            end
            MODE_THRESH: begin
                if (luma >= thresh) begin
                    r_ch = '1;
                    g_ch = '1;
                    b_ch = '1;
                end
            end
            default: ;
        endcase
        pix_next = {out_bits(r_ch), out_bits(g_ch), out_bits(b_ch)};
    end

    // ------------------------------------------------------------------
    // Output register: the buffer data is sampled on the tick at which its
    // delayed valid bit sits at the end of the pipe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pixel_rgb <= '0;
        end else if (ptick) begin
            pixel_rgb <= valid_q[RD_LAT] ? pix_next : '0;
        end
    end

endmodule : vga_window_compositor

// File: tb/tb_vga_window_compositor.sv
// ---------------------------------------------------------------------------
// tb_vga_window_compositor
//   Drives a shrunken VGA raster (24x18 total, 20x16 active) with a randomly
//   gapped ptick, models the frame buffer as a RD_LAT-tick pipeline over
//   random contents, and compares every clk against a coordinate-based
//   reference model of the compositor.
// ---------------------------------------------------------------------------
module tb_vga_window_compositor;
    import vga_pkg::*;

    localparam int WIN_W   = 12;
    localparam int WIN_H   = 10;
    localparam int X_OFF   = 3;
    localparam int Y_OFF   = 2;
    localparam int ADDR_W  = 7;
    localparam int CH_W    = 4;
    localparam int OUT_BPC = 4;
    localparam int RD_LAT  = 3;

    localparam int PIX_W = 3 * CH_W;
    localparam int OUT_W = 3 * OUT_BPC;
    localparam int NPIX  = WIN_W * WIN_H;

    localparam int H_ACT = 20;
    localparam int H_TOT = 24;
    localparam int V_ACT = 16;
    localparam int V_TOT = 18;
    localparam int N_FRAMES  = 8;
    localparam int RST_FRAME = 5;

    logic               clk_50;
    logic               rst_n;
    logic               ptick;
    logic               active;
    logic [9:0]         xpos;
    logic [9:0]         ypos;
    logic [1:0]         mode_sel;
    logic [CH_W-1:0]    thresh;
    logic [ADDR_W-1:0]  rd_addr_rgb;
    logic [PIX_W-1:0]   rd_data_rgb;
    logic [ADDR_W-1:0]  rd_addr_gray;
    logic [CH_W-1:0]    rd_data_gray;
    logic [OUT_W-1:0]   pixel_rgb;
    logic [1:0]         mode_active;
    logic               frame_start;

    vga_window_compositor #(
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H),
        .X_OFF   (X_OFF),
        .Y_OFF   (Y_OFF),
        .ADDR_W  (ADDR_W),
        .CH_W    (CH_W),
        .OUT_BPC (OUT_BPC),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .ptick        (ptick),
        .active       (active),
        .xpos         (xpos),
        .ypos         (ypos),
        .mode_sel     (mode_sel),
        .thresh       (thresh),
        .rd_addr_rgb  (rd_addr_rgb),
        .rd_data_rgb  (rd_data_rgb),
        .rd_addr_gray (rd_addr_gray),
        .rd_data_gray (rd_data_gray),
        .pixel_rgb    (pixel_rgb),
        .mode_active  (mode_active),
        .frame_start  (frame_start)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame buffer contents and reference pixel function
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] mem_rgb  [NPIX];
    logic [CH_W-1:0]  mem_gray [NPIX];

    function automatic int chan(input logic [PIX_W-1:0] c, input int idx);
        return int'((c >> (idx * CH_W)) & PIX_W'((1 << CH_W) - 1));
    endfunction

    function automatic int ref_luma(input logic [PIX_W-1:0] c);
        return (2 * chan(c, 2) + 5 * chan(c, 1) + chan(c, 0)) / 8;
    endfunction

    function automatic logic [OUT_BPC-1:0] top_bits(input int v);
        return OUT_BPC'(v >> (CH_W - OUT_BPC));
    endfunction

    function automatic logic [OUT_W-1:0] ref_pixel(input int addr, input int m, input int th);
        int r, g, b, l;
        r = chan(mem_rgb[addr], 2);
        g = chan(mem_rgb[addr], 1);
        b = chan(mem_rgb[addr], 0);
        l = ref_luma(mem_rgb[addr]);
        case (m)
            1:       begin r = int'(mem_gray[addr]); g = r; b = r; end
            2:       begin r = l; g = l; b = l; end
            3:       begin r = (l >= th) ? (1 << CH_W) - 1 : 0; g = r; b = r; end
            default: ;
        endcase
        return {top_bits(r), top_bits(g), top_bits(b)};
    endfunction

    // ------------------------------------------------------------------
    // Reference model and per-clk compare
    // ------------------------------------------------------------------
    typedef struct {
        bit valid;
        bit synced;
        int addr;
    } ent_t;

    ent_t             pix_q[$];
    ent_t             e_new;
    ent_t             e_out;
    int               exp_addr;
    int               exp_mode;
    bit               exp_fs;
    logic [OUT_W-1:0] exp_pix;
    bit               exp_pix_known;
    bit               synced;
    bit               in_w;
    bit               org;
    int               xi, yi, ai;
    bit               lit_pending;
    int               lit_addr, lit_mode, lit_th;
    int               fs_dut = 0;
    int               fs_model = 0;

    task automatic model_reset();
        ent_t blank;
        blank.valid  = 1'b0;
        blank.synced = 1'b0;
        blank.addr   = 0;
        pix_q.delete();
        for (int i = 0; i < RD_LAT + 1; i++) pix_q.push_back(blank);
        exp_addr      = 0;
        exp_mode      = 0;
        exp_fs        = 1'b0;
        exp_pix       = '0;
        exp_pix_known = 1'b1;
        synced        = 1'b0;
        lit_pending   = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_50);
            if (!rst_n) begin
                model_reset();
            end else begin
                xi     = int'(xpos);
                yi     = int'(ypos);
                in_w   = active && xi >= X_OFF && xi < X_OFF + WIN_W
                                && yi >= Y_OFF && yi < Y_OFF + WIN_H;
                org    = active && xi == X_OFF && yi == Y_OFF;
                exp_fs = ptick && org;
                if (ptick) begin
                    if (org) synced = 1'b1;
                    ai = (yi - Y_OFF) * WIN_W + (xi - X_OFF);
                    if (in_w) exp_addr = ai;
                    e_new.valid  = in_w;
                    e_new.synced = synced;
                    e_new.addr   = in_w ? ai : 0;
                    pix_q.push_back(e_new);
                    e_out = pix_q.pop_front();
                    if (!e_out.valid) begin
                        exp_pix       = '0;
                        exp_pix_known = 1'b1;
                    end else if (e_out.synced) begin
                        // Pixels still in flight render with the mode that
                        // was in force before this tick.
                        exp_pix       = ref_pixel(e_out.addr, exp_mode, int'(thresh));
                        exp_pix_known = 1'b1;
                        lit_pending   = 1'b1;
                        lit_addr      = e_out.addr;
                        lit_mode      = exp_mode;
                        lit_th        = int'(thresh);
                    end else begin
                        exp_pix_known = 1'b0;
                    end
                    if (org) exp_mode = int'(mode_sel);
                end
            end
            #1;
            check("frame_start", 32'(frame_start), 32'(exp_fs));
            check("mode_active", 32'(mode_active), 32'(exp_mode));
            if (!rst_n || synced) begin
                check("rd_addr_rgb", 32'(rd_addr_rgb), 32'(exp_addr));
                check("rd_addr_gray", 32'(rd_addr_gray), 32'(exp_addr));
            end
            if (exp_pix_known) check("pixel_rgb", 32'(pixel_rgb), 32'(exp_pix));
            if (frame_start) fs_dut++;
            if (exp_fs) fs_model++;
            if (lit_pending) begin
                lit_pending = 1'b0;
                if (lit_addr == 5 && lit_mode == 0) check("lit_rgb_F00", 32'(pixel_rgb), 32'h0F00);
                if (lit_addr == 5 && lit_mode == 1) check("lit_graybuf_A", 32'(pixel_rgb), 32'h0AAA);
                if (lit_addr == 5 && lit_mode == 2) check("lit_calc_F00", 32'(pixel_rgb), 32'h0333);
                if (lit_addr == 6 && lit_mode == 2) check("lit_calc_FFF", 32'(pixel_rgb), 32'h0FFF);
                if (lit_addr == 7 && lit_mode == 3 && lit_th == 8)
                    check("lit_thr_0F0", 32'(pixel_rgb), 32'h0FFF);
                if (lit_addr == 8 && lit_mode == 3 && lit_th == 8)
                    check("lit_thr_00F", 32'(pixel_rgb), 32'h0000);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer read model: RD_LAT-tick pipeline advancing on ptick
    // ------------------------------------------------------------------
    int mp_rgb  [RD_LAT];
    int mp_gray [RD_LAT];
    int seen_rgb  = 0;
    int seen_gray = 0;

    // Called once per negedge, before new inputs are driven: ptick still
    // holds the value the DUT just saw at the preceding posedge.
    task automatic mem_step();
        if (ptick) begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                mp_rgb[i]  = mp_rgb[i-1];
                mp_gray[i] = mp_gray[i-1];
            end
            mp_rgb[0]  = seen_rgb;
            mp_gray[0] = seen_gray;
        end
        rd_data_rgb  = (mp_rgb[RD_LAT-1]  < NPIX) ? mem_rgb[mp_rgb[RD_LAT-1]]   : '0;
        rd_data_gray = (mp_gray[RD_LAT-1] < NPIX) ? mem_gray[mp_gray[RD_LAT-1]] : '0;
        seen_rgb  = int'(rd_addr_rgb);
        seen_gray = int'(rd_addr_gray);
    endtask

    // Present pixel (x,y) with a random number of idle clocks first; idle
    // clocks carry junk coordinates that must not move any state.
    task automatic drive_pixel(input int x, input int y);
        int tries;
        tries = 0;
        forever begin
            @(negedge clk_50);
            mem_step();
            tries++;
            if (tries < 6 && $urandom_range(0, 2) == 0) begin
                ptick  = 1'b0;
                xpos   = 10'($urandom_range(0, H_TOT - 1));
                ypos   = 10'($urandom_range(0, V_TOT - 1));
                active = 1'($urandom_range(0, 1));
            end else begin
                ptick  = 1'b1;
                xpos   = 10'(x);
                ypos   = 10'(y);
                active = (x < H_ACT) && (y < V_ACT);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_50);
        mem_step();
        rst_n = 1'b0;
        ptick = 1'b0;
        @(posedge clk_50);
        #1;
        check("rst_pixel", 32'(pixel_rgb), 32'h0);
        check("rst_addr", 32'(rd_addr_rgb), 32'h0);
        check("rst_mode", 32'(mode_active), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        @(negedge clk_50);
        mem_step();
        @(negedge clk_50);
        mem_step();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int frame_modes [N_FRAMES] = '{0, 1, 2, 3, 0, 3, 2, 0};

    initial begin
        int fmode;
        for (int i = 0; i < NPIX; i++) begin
            mem_rgb[i]  = PIX_W'($urandom);
            mem_gray[i] = CH_W'($urandom);
        end
        mem_rgb[5]  = 12'hF00;
        mem_gray[5] = 4'hA;
        mem_rgb[6]  = 12'hFFF;
        mem_rgb[7]  = 12'h0F0;
        mem_rgb[8]  = 12'h00F;
        for (int i = 0; i < RD_LAT; i++) begin
            mp_rgb[i]  = 0;
            mp_gray[i] = 0;
        end

        rst_n        = 1'b0;
        ptick        = 1'b0;
        active       = 1'b0;
        xpos         = '0;
        ypos         = '0;
        mode_sel     = 2'd2;
        thresh       = 4'd8;
        rd_data_rgb  = '0;
        rd_data_gray = '0;

        repeat (3) begin
            @(negedge clk_50);
            mem_step();
        end
        check("init_pixel", 32'(pixel_rgb), 32'h0);
        check("init_mode", 32'(mode_active), 32'h0);
        rst_n = 1'b1;

        for (int f = 0; f < N_FRAMES; f++) begin
            fmode    = (f == 4) ? int'($urandom_range(0, 3)) : frame_modes[f];
            mode_sel = 2'(fmode);
            thresh   = (f == 4) ? CH_W'($urandom_range(0, 15)) : CH_W'(8);
            for (int y = 0; y < V_TOT; y++) begin
                for (int x = 0; x < H_TOT; x++) begin
                    // Request a different mode mid-window; it must wait for
                    // the next frame start.
                    if (f == 4 && y == 5 && x == 0) mode_sel = 2'(fmode + 1);
                    if (f == RST_FRAME && y == 6 && x == 8) do_reset();
                    drive_pixel(x, y);
                end
            end
        end

        repeat (4) begin
            @(negedge clk_50);
            mem_step();
            ptick  = 1'b1;
            active = 1'b0;
        end
        @(posedge clk_50);
        #2;
        check("fs_count_vs_model", 32'(fs_dut), 32'(fs_model));
        check("fs_count_total", 32'(fs_dut), 32'(N_FRAMES));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_vga_window_compositor
